// File: rtl/calc_op_sequencer_pkg.sv
// Shared key codes, ALU opcodes and state encoding for the keypad operand sequencer.
package calc_pkg;

  localparam logic [4:0] OP_ADD    = 5'h10;
  localparam logic [4:0] OP_MUL    = 5'h11;
  localparam logic [4:0] OP_AND    = 5'h12;
  localparam logic [4:0] OP_SUB    = 5'h14;
  localparam logic [4:0] OP_OR     = 5'h15;
  localparam logic [4:0] KEY_EXEC  = 5'h18;
  localparam logic [4:0] KEY_CLEAR = 5'h19;

  typedef enum logic [1:0] {
    ST_ENTER_A  = 2'd0,
    ST_ENTER_B  = 2'd1,
    ST_SHOW_RES = 2'd2
  } calc_state_t;

  // Op keys are the ALU opcodes themselves, so they pass straight through.
  function automatic logic is_op_key(input logic [4:0] code);
    return (code == OP_ADD) || (code == OP_MUL) || (code == OP_AND) ||
           (code == OP_SUB) || (code == OP_OR);
  endfunction

endpackage

// File: rtl/calc_op_sequencer_if.sv
// Key input, ALU issue/return and display/status signals of the operand sequencer.
interface calc_op_sequencer_if #(
    parameter int unsigned WIDTH = 16
);
    logic             key_valid;
    logic [4:0]       key_code;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [4:0]       alu_op;
    logic [WIDTH-1:0] alu_c;
    logic [WIDTH-1:0] disp_value;
    logic [1:0]       state_o;
    logic             result_valid;
    logic             key_err;

    modport master (
        input  key_valid, key_code, alu_c,
        output alu_a, alu_b, alu_op, disp_value, state_o, result_valid, key_err
    );

    modport slave (
        output key_valid, key_code, alu_c,
        input  alu_a, alu_b, alu_op, disp_value, state_o, result_valid, key_err
    );
endinterface

// File: rtl/calc_op_sequencer.sv
// Accumulates hex operands and an opcode from key events, issues them to the ALU and
// latches/display the result, with chaining of the last result into operand A.
module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 4
) (
    input logic clk,
    input logic reset,
    calc_op_sequencer_if.master bus
);
    localparam int unsigned CntW = $clog2(DIGITS + 1);

    localparam logic [1:0] StEnterA  = ST_ENTER_A;
    localparam logic [1:0] StEnterB  = ST_ENTER_B;
    localparam logic [1:0] StShowRes = ST_SHOW_RES;

    logic [1:0]       st_q, st_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] disp_q, disp_d;
    logic [4:0]       op_q, op_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             rv_q, rv_d;
    logic             err_q, err_d;
    logic [3:0]       digit;

    assign digit = bus.key_code[3:0];

    always_comb begin
        st_d  = st_q;
        a_d   = a_q;
        b_d   = b_q;
        res_d = res_q;
        op_d  = op_q;
        cnt_d = cnt_q;
        rv_d  = 1'b0;
        err_d = 1'b0;

        if (bus.key_valid) begin
            if (bus.key_code == KEY_CLEAR) begin
                st_d  = StEnterA;
                a_d   = '0;
                b_d   = '0;
                res_d = '0;
                op_d  = '0;
                cnt_d = '0;
            end else if (!bus.key_code[4]) begin
                if (st_q == StShowRes) begin
                    // A digit after a result starts a fresh calculation.
                    st_d  = StEnterA;
                    a_d   = {{(WIDTH - 4){1'b0}}, digit};
                    b_d   = '0;
                    op_d  = '0;
                    cnt_d = CntW'(1);
                end else if (cnt_q == CntW'(DIGITS)) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                    if (st_q == StEnterB) begin
                        b_d = {b_q[WIDTH-5:0], digit};
                    end else begin
                        a_d = {a_q[WIDTH-5:0], digit};
                    end
                end
            end else if (is_op_key(bus.key_code)) begin
                op_d = bus.key_code;
                if (st_q != StEnterB) begin
                    if (st_q == StShowRes) begin
                        a_d = res_q;
                    end
                    st_d  = StEnterB;
                    b_d   = '0;
                    cnt_d = '0;
                end
            end else if (bus.key_code == KEY_EXEC) begin
                if (st_q == StEnterB) begin
                    st_d  = StShowRes;
                    res_d = bus.alu_c;
                    rv_d  = 1'b1;
                end
            end else begin
                err_d = 1'b1;
            end
        end

        case (st_d)
            StEnterA:  disp_d = a_d;
            StEnterB:  disp_d = (cnt_d == '0) ? a_d : b_d;
            StShowRes: disp_d = res_d;
            default:   disp_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q   <= StEnterA;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            disp_q <= '0;
            op_q   <= '0;
            cnt_q  <= '0;
            rv_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            a_q    <= a_d;
            b_q    <= b_d;
            res_q  <= res_d;
            disp_q <= disp_d;
            op_q   <= op_d;
            cnt_q  <= cnt_d;
            rv_q   <= rv_d;
            err_q  <= err_d;
        end
    end

    assign bus.alu_a        = a_q;
    assign bus.alu_b        = b_q;
    assign bus.alu_op       = op_q;
    assign bus.disp_value   = disp_q;
    assign bus.state_o      = st_q;
    assign bus.result_valid = rv_q;
    assign bus.key_err      = err_q;
endmodule

// File: doc/calc_op_sequencer.md
Name: calc_op_sequencer

Overview:
- Keypad-driven operand/opcode sequencer that sits on the issuing side of the team's 16-bit combinational ALU.
- Accepts decoded key events and accumulates hex operands A and B plus an operation code.
- Presents them to the ALU as registered signals, latches the ALU result on "execute", and drives the VGA display value with a status code.
- Supports result chaining: the last result becomes the next operand A.

Parameters:
- WIDTH, 16, operand/result width; must equal the ALU entradas/salida width.
- DIGITS, 4, maximum hex digits per operand; WIDTH = 4*DIGITS.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- key_valid  in  1  one-cycle strobe; key_code is valid this cycle
- key_code  in  5  0x00-0x0F hex digit; 0x10 ADD, 0x11 MUL, 0x12 AND, 0x14 SUB, 0x15 OR, 0x18 EXEC, 0x19 CLEAR
- alu_a  out  WIDTH  operand A to ALU (registered)
- alu_b  out  WIDTH  operand B to ALU (registered)
- alu_op  out  5  opcode to ALU (registered)
- alu_c  in  WIDTH  ALU result (combinational from alu_a, alu_b, alu_op)
- disp_value  out  WIDTH  value for the display
- state_o  out  2  current state: 0 ENTER_A, 1 ENTER_B, 2 SHOW_RES
- result_valid  out  1  one-cycle pulse when a result is latched
- key_err  out  1  one-cycle pulse on a rejected key

Behaviour:
- Reset (async, active-high) sets:
  - state ENTER_A
  - A = B = result = 0, alu_op = 5'b00000, digit count = 0
  - result_valid = 0, key_err = 0
- Key encoding: op key codes equal the ALU opcodes (ADD 10000, MUL 10001, AND 10010, SUB 10100, OR 10101).
- All state changes occur on the clk edge where key_valid = 1. key_valid = 0 means hold.
- Digit entry: operand <= {operand[WIDTH-5:0], digit}; digit count increments.
  - If count == DIGITS, the digit is ignored and key_err pulses.
- ENTER_A:
  - digit: shift into A.
  - op key: alu_op <= code; B <= 0; count <= 0; go to ENTER_B.
  - EXEC: ignored, no error.
- ENTER_B:
  - digit: shift into B.
  - op key: replace alu_op; B and count are unchanged.
  - EXEC: result <= alu_c; result_valid = 1 on the following cycle; go to SHOW_RES.
- SHOW_RES:
  - digit: A <= {0, digit}; B <= 0; count <= 1; alu_op <= 0; go to ENTER_A.
  - op key: A <= result; alu_op <= code; B <= 0; count <= 0; go to ENTER_B (chaining).
  - EXEC: ignored.
- CLEAR in any state is equivalent to reset (synchronous). It does not pulse key_err.
- Undefined codes (0x13, 0x16, 0x17, 0x1A-0x1F): no state change; key_err pulses for one cycle.
- disp_value (registered with state):
  - ENTER_A shows A.
  - ENTER_B shows B, or shows A while count == 0.
  - SHOW_RES shows result.
- Latency: key accepted at edge n; alu_a/alu_b/alu_op/disp_value are updated after edge n. On EXEC, result is sampled from alu_c at edge n and is visible on disp_value after edge n.
- Arithmetic is done entirely by the ALU:
  - SUB returns |A-B|.
  - MUL is truncated to the low WIDTH bits.
  - The block does not detect overflow.
- Back-to-back keys on consecutive cycles must all be processed; there are no idle cycles.
- Reset asserted mid-entry discards all partial operands immediately (async).

Decomposition:
- Package calc_pkg:
  - opcode localparams OP_ADD, OP_MUL, OP_AND, OP_SUB, OP_OR
  - key codes KEY_EXEC, KEY_CLEAR
  - state enum typedef calc_state_t
  - function is_op_key()
- No sub-module inside. The ALU is instantiated beside this block at the top level and wired alu_a/alu_b/alu_op -> A/B/op, C -> alu_c.

Test Plan:
- Keys 3, ADD, 5, EXEC -> disp_value 0x0008, result_valid pulses once, state_o = 2.
- Keys 2, SUB, 9, EXEC -> disp_value 0x0007 (absolute difference); with A = 0x0009, B = 0x0002 -> also 0x0007.
- Keys 1,0,0,0, MUL, 1,0, EXEC -> 0x0000 (0x10000 truncated); then op ADD, 5, EXEC (chaining) -> 0x0005.
- Keys A,B,C,D,E -> A = 0xABCD, key_err pulses on E only; code 0x13 -> key_err pulses, state unchanged.
- Keys F, AND, 3, OR, EXEC -> alu_op = 10101, result 0x000F.
- Keys 7, ADD, 2, then reset asserted between clk edges -> all outputs 0 immediately; CLEAR in SHOW_RES -> state 0, disp_value 0.
